// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch-side controller for the 64-bit LEGv8 program counter. It steers the
// external counter through PS/pc_k, issues one word read at a time to
// instruction memory over a req/ack handshake, and queues each returned
// instruction, tagged with its PC, in a small FIFO that decode drains over a
// valid/ready handshake. Branch redirects reload the counter, flush the FIFO
// and discard any read already in flight.
//
// Parameters
//   ADDR_W  address / PC width
//   INSTR_W instruction width
//   DEPTH   FIFO entries (power of two, 2..16)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   PC, PC4      current PC and PC+4 from the counter
//   PS, pc_k     counter select and operand (combinational)
//                00 hold, 01 PC+4, 10 pc_k, 11 PC4+pc_k
//   imem_req     read request, held with imem_addr until imem_ack
//   imem_addr    read address
//   imem_ack     read complete, imem_rdata valid this cycle
//   imem_rdata   read data
//   instr_valid  FIFO head valid
//   instr_ready  decode accepts the head
//   instr        head instruction (zero when empty)
//   instr_pc     PC of head instruction (zero when empty)
//   redirect     one-cycle branch redirect
//   redirect_abs 1: absolute target, 0: PC4-relative target
//   redirect_k   target or offset
//   fifo_count   FIFO occupancy
//   stall_count  cycles spent waiting on imem_ack, saturating
//                (only when FETCH_STALL_COUNT_EN is defined)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        PC,
  input  logic [ADDR_W-1:0]        PC4,
  output logic [1:0]               PS,
  output logic [ADDR_W-1:0]        pc_k,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_W-1:0]       instr,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     redirect,
  input  logic                     redirect_abs,
  input  logic [ADDR_W-1:0]        redirect_k,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [15:0]              stall_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_ABS  = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  // FETCH: no read pending. WAIT: read pending, response kept.
  // DRAIN: read pending, response belongs to a squashed path and is dropped.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state, state_next;
  logic                req_next;
  logic [ADDR_W-1:0]   addr_next;
  logic                push, pop, flush;
  logic [CNT_W-1:0]    count_next;

  logic [INSTR_W-1:0]  instr_mem [DEPTH];
  logic [ADDR_W-1:0]   pc_mem    [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;

  // ---------------------------------------------------------------------------
  // Next-state, counter control and FIFO strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    req_next   = imem_req;
    addr_next  = imem_addr;
    PS         = PS_HOLD;
    pc_k       = '0;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    count_next = fifo_count;

    // While reset is held the counter must see hold, whatever ack/redirect do.
    if (reset) begin
      flush = redirect;
      push  = (state == S_WAIT) && imem_ack && !redirect;
      pop   = instr_valid && instr_ready && !redirect;

      if (redirect) begin
        PS         = redirect_abs ? PS_ABS : PS_REL;
        pc_k       = redirect_k;
        count_next = '0;
      end else begin
        count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
      end

      // A launch only happens when the slot is guaranteed after this edge,
      // so the single outstanding read always has room to land.
      unique case (state)
        S_FETCH: begin
          // After a redirect the counter loads at this edge; launch from the
          // new PC on the next one.
          if (!redirect && count_next < DEPTH_C) begin
            req_next   = 1'b1;
            addr_next  = PC;
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            if (redirect) begin
              req_next   = 1'b0;
              state_next = S_FETCH;
            end else begin
              PS = PS_INC;
              // The counter advances at this same edge, so the next word is
              // at PC4, not the PC seen this cycle.
              if (count_next < DEPTH_C) begin
                req_next  = 1'b1;
                addr_next = PC4;
              end else begin
                req_next   = 1'b0;
                state_next = S_FETCH;
              end
            end
          end else if (redirect) begin
            // The request stays up; its response will be thrown away.
            state_next = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            req_next   = 1'b0;
            state_next = S_FETCH;
          end
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and request registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state     <= state_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      fifo_count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // DEPTH is a power of two, so natural overflow wraps modulo DEPTH.
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy decides what is valid and
  // the head outputs are forced to zero when the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= PC;
    end
  end

  assign instr_valid = (fifo_count != '0);
  assign instr       = instr_valid ? instr_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]    : '0;

`ifdef FETCH_STALL_COUNT_EN
  // Memory-latency profiling: cycles with a request up and no response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (imem_req && !imem_ack && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Bench for instruction_fetch_unit. A small PC-counter plant follows PS/pc_k.
// A table of per-cycle vectors drives memory ack/data, decode ready and
// redirects, and lists the expected request, counter controls and occupancy.
// Kept instructions go into a scoreboard queue and are compared against the
// FIFO head when decode pops. A hand-written sequence covers reset mid-read.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [ADDR_W-1:0]    pc_m  = '0;
  logic [ADDR_W-1:0]    PC, PC4;
  logic [1:0]           PS;
  logic [ADDR_W-1:0]    pc_k;
  logic                 imem_req;
  logic [ADDR_W-1:0]    imem_addr;
  logic                 imem_ack = 1'b0;
  logic [INSTR_W-1:0]   imem_rdata = '0;
  logic                 instr_valid;
  logic                 instr_ready = 1'b0;
  logic [INSTR_W-1:0]   instr;
  logic [ADDR_W-1:0]    instr_pc;
  logic                 redirect = 1'b0;
  logic                 redirect_abs = 1'b0;
  logic [ADDR_W-1:0]    redirect_k = '0;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef FETCH_STALL_COUNT_EN
  logic [15:0]          stall_count;
`endif

  instruction_fetch_unit #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .PC          (PC),
    .PC4         (PC4),
    .PS          (PS),
    .pc_k        (pc_k),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_abs(redirect_abs),
    .redirect_k  (redirect_k),
    .fifo_count  (fifo_count)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clock = ~clock;

  // Program-counter plant controlled by PS/pc_k.
  assign PC  = pc_m;
  assign PC4 = pc_m + 64'd4;
  always @(posedge clock) begin
    case (PS)
      2'b01:   pc_m <= pc_m + 64'd4;
      2'b10:   pc_m <= pc_k;
      2'b11:   pc_m <= pc_m + 64'd4 + pc_k;
      default: pc_m <= pc_m;
    endcase
  end

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic        abs_t;
    logic [63:0] k;
    logic        e_req;
    logic [63:0] e_addr;
    logic [1:0]  e_ps;
    logic [63:0] e_pck;
    int          e_cnt;
    logic        e_valid;
    logic        keep;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic add(input logic ack, input logic [31:0] rd, input logic rdy,
                     input logic rdir, input logic ab, input logic [63:0] k,
                     input logic ereq, input logic [63:0] eaddr, input logic [1:0] eps,
                     input logic [63:0] epck, input int ecnt, input logic ev,
                     input logic keep);
    vec_t v;
    v.ack = ack;  v.rdata = rd;  v.ready = rdy;  v.redir = rdir;  v.abs_t = ab;
    v.k = k;  v.e_req = ereq;  v.e_addr = eaddr;  v.e_ps = eps;  v.e_pck = epck;
    v.e_cnt = ecnt;  v.e_valid = ev;  v.keep = keep;
    vecs.push_back(v);
  endtask

  // Zero-wait fill from PC=0 with decode stalled: four words, then idle full.
  task automatic add_fill();
    add(0, 32'h0,        0, 0, 0, 0, 0, 64'h0, 2'b00, 0, 0, 0, 0);
    add(1, 32'h8B000000, 0, 0, 0, 0, 1, 64'h0, 2'b01, 0, 0, 0, 1);
    add(1, 32'h8B000001, 0, 0, 0, 0, 1, 64'h4, 2'b01, 0, 1, 1, 1);
    add(1, 32'h8B000002, 0, 0, 0, 0, 1, 64'h8, 2'b01, 0, 2, 1, 1);
    add(1, 32'h8B000003, 0, 0, 0, 0, 1, 64'hC, 2'b01, 0, 3, 1, 1);
    add(0, 32'h0,        0, 0, 0, 0, 0, 64'h0, 2'b00, 0, 4, 1, 0);
    add(0, 32'h0,        0, 0, 0, 0, 0, 64'h0, 2'b00, 0, 4, 1, 0);
  endtask

  initial begin
    vec_t r;
    exp_t e;

    //   ack rdata         rdy rdr abs k        | req addr     ps     pc_k    cnt v keep
    add_fill();
    // One pop frees a slot: relaunch at PC=0x10.
    add(0, 32'h0,        1, 0, 0, 0,      0, 64'h0,   2'b00, 0,      4, 1, 0);
    // Three wait states while decode drains, ack on the fourth request cycle.
    add(0, 32'h0,        1, 0, 0, 0,      1, 64'h10,  2'b00, 0,      3, 1, 0);
    add(0, 32'h0,        1, 0, 0, 0,      1, 64'h10,  2'b00, 0,      2, 1, 0);
    add(0, 32'h0,        1, 0, 0, 0,      1, 64'h10,  2'b00, 0,      1, 1, 0);
    add(1, 32'h8B000004, 0, 0, 0, 0,      1, 64'h10,  2'b01, 0,      0, 0, 1);
    add(0, 32'h0,        0, 0, 0, 0,      1, 64'h14,  2'b00, 0,      1, 1, 0);
    // Back-to-back: push and pop each cycle, occupancy stays at one.
    add(1, 32'h8B000005, 1, 0, 0, 0,      1, 64'h14,  2'b01, 0,      1, 1, 1);
    add(1, 32'h8B000006, 1, 0, 0, 0,      1, 64'h18,  2'b01, 0,      1, 1, 1);
    add(1, 32'h8B000007, 1, 0, 0, 0,      1, 64'h1C,  2'b01, 0,      1, 1, 1);
    // Absolute redirect to 0x100 while 0x20 is pending; ack 2 cycles later.
    add(0, 32'h0,        0, 1, 1, 64'h100, 1, 64'h20, 2'b10, 64'h100, 1, 1, 0);
    add(0, 32'h0,        0, 0, 0, 0,      1, 64'h20,  2'b00, 0,      0, 0, 0);
    add(1, 32'hDEADBEEF, 0, 0, 0, 0,      1, 64'h20,  2'b00, 0,      0, 0, 0);
    add(0, 32'h0,        0, 0, 0, 0,      0, 64'h0,   2'b00, 0,      0, 0, 0);
    add(0, 32'h0,        0, 0, 0, 0,      1, 64'h100, 2'b00, 0,      0, 0, 0);
    add(1, 32'h8B000008, 0, 0, 0, 0,      1, 64'h100, 2'b01, 0,      0, 0, 1);
    // Redirect and ack together: redirect wins (PS=10), data dropped, flush.
    add(1, 32'hCAFEF00D, 0, 1, 1, 64'h0,  1, 64'h104, 2'b10, 64'h0,  1, 1, 0);
    add_fill();
    // Relative redirect while idle at PC=0x10: pop ignored, flush, go to 0x54.
    add(0, 32'h0,        1, 1, 0, 64'h40, 0, 64'h0,   2'b11, 64'h40, 4, 1, 0);
    add(0, 32'h0,        0, 0, 0, 0,      0, 64'h0,   2'b00, 0,      0, 0, 0);
    add(0, 32'h0,        0, 0, 0, 0,      1, 64'h54,  2'b00, 0,      0, 0, 0);
    // Load three entries and leave a read of 0x60 pending.
    add(1, 32'h8B000009, 0, 0, 0, 0,      1, 64'h54,  2'b01, 0,      0, 0, 1);
    add(1, 32'h8B00000A, 0, 0, 0, 0,      1, 64'h58,  2'b01, 0,      1, 1, 1);
    add(1, 32'h8B00000B, 0, 0, 0, 0,      1, 64'h5C,  2'b01, 0,      2, 1, 1);
    add(0, 32'h0,        0, 0, 0, 0,      1, 64'h60,  2'b00, 0,      3, 1, 0);

    // Reset state, with ack and redirect active to show they are ignored.
    imem_ack = 1'b1;  redirect = 1'b1;  redirect_k = 64'h1234;
    #1;
    check("rst req",   imem_req, 0);
    check("rst addr",  imem_addr, 0);
    check("rst ps",    PS, 0);
    check("rst pck",   pc_k, 0);
    check("rst valid", instr_valid, 0);
    check("rst cnt",   fifo_count, 0);
    @(negedge clock);
    imem_ack = 1'b0;  redirect = 1'b0;  redirect_k = '0;
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      imem_ack     = r.ack;
      imem_rdata   = r.rdata;
      instr_ready  = r.ready;
      redirect     = r.redir;
      redirect_abs = r.abs_t;
      redirect_k   = r.k;
      #1;
      check($sformatf("v%0d req", i), imem_req, r.e_req);
      if (r.e_req) check($sformatf("v%0d addr", i), imem_addr, r.e_addr);
      check($sformatf("v%0d ps", i), PS, r.e_ps);
      check($sformatf("v%0d pck", i), pc_k, r.e_pck);
      check($sformatf("v%0d cnt", i), fifo_count, r.e_cnt);
      check($sformatf("v%0d valid", i), instr_valid, r.e_valid);
      if (r.ready && r.e_valid && !r.redir) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL v%0d scoreboard: pop with no expected entry", i);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d instr", i), instr, e.ins);
          check($sformatf("v%0d instr_pc", i), instr_pc, e.pc);
        end
      end
      if (r.redir) exp_q.delete();
      if (r.keep) exp_q.push_back('{pc: r.e_addr, ins: r.rdata});
      @(negedge clock);
    end

    // Reset mid-WAIT with three entries queued: outputs clear immediately.
    reset = 1'b0;  imem_ack = 1'b1;  redirect = 1'b1;  redirect_abs = 1'b0;
    redirect_k = 64'h1234;  instr_ready = 1'b1;
    #1;
    check("mid req",      imem_req, 0);
    check("mid addr",     imem_addr, 0);
    check("mid ps",       PS, 0);
    check("mid pck",      pc_k, 0);
    check("mid valid",    instr_valid, 0);
    check("mid instr",    instr, 0);
    check("mid instr_pc", instr_pc, 0);
    check("mid cnt",      fifo_count, 0);
`ifdef FETCH_STALL_COUNT_EN
    check("mid stall",    stall_count, 0);
`endif
    exp_q.delete();
    @(negedge clock);
    check("held req", imem_req, 0);
    imem_ack = 1'b0;  redirect = 1'b0;  redirect_k = '0;  instr_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rel req", imem_req, 0);
`ifdef FETCH_STALL_COUNT_EN
    check("rel stall", stall_count, 0);
`endif
    @(negedge clock);
    #1;
    // PC was held through reset, so the first request is at 0x60.
    check("post req",  imem_req, 1);
    check("post addr", imem_addr, 64'h60);
    check("post cnt",  fifo_count, 0);
`ifdef FETCH_STALL_COUNT_EN
    check("post stall", stall_count, 0);
    @(negedge clock);
    #1;
    check("stall one", stall_count, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Fetch-side controller paired with the 64-bit LEGv8 program counter.
- Drives the counter's PS select and offset operand, reads the current PC/PC4 back, and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions, tagged with their PC, in a small FIFO for decode over a valid/ready handshake.
- Handles branch redirects, including discarding a read that is in flight when the redirect arrives.

## Interface
- ADDR_W, 64, address/PC width
- INSTR_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, 2..16
- clock  input  1  rising-edge clock; the block's only clock
- reset  input  1  asynchronous, active-low reset
- PC  input  ADDR_W  current program counter value
- PC4  input  ADDR_W  PC+4 from the program counter
- PS  output  2  counter select: 00 hold, 01 PC<=PC+4, 10 PC<=pc_k, 11 PC<=PC4+pc_k
- pc_k  output  ADDR_W  counter operand
- imem_req  output  1  read request
- imem_addr  output  ADDR_W  read address
- imem_ack  input  1  read complete; imem_rdata valid this cycle
- imem_rdata  input  INSTR_W  read data
- instr_valid  output  1  FIFO head valid
- instr_ready  input  1  decode accepts head
- instr  output  INSTR_W  head instruction
- instr_pc  output  ADDR_W  PC of head instruction
- redirect  input  1  one-cycle branch redirect
- redirect_abs  input  1  1: absolute target, 0: PC4-relative target
- redirect_k  input  ADDR_W  target or offset
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FSM states:
  - FETCH: no read pending.
  - WAIT: read pending, response kept.
  - DRAIN: read pending, response discarded.
- Launch: in FETCH, imem_req is raised at an edge when occupancy after that edge < DEPTH.
  - Address is PC4 if launching on an ack edge, otherwise PC.
  - State moves to WAIT.
- Request rule: once raised, imem_req and imem_addr stay stable until the imem_ack cycle. A request is never withdrawn; redirect and reset are the only ways a response is ignored.
- Ack in WAIT, no redirect:
  - Push {PC, imem_rdata}.
  - PS=01 combinationally in that cycle.
  - Relaunch at the same edge if space allows, else FETCH with imem_req low.
- Redirect in any state:
  - PS=10 (redirect_abs=1) or 11 (redirect_abs=0), pc_k=redirect_k, combinationally in that cycle.
  - FIFO flushed at the edge.
  - A pending read with no ack this cycle goes to DRAIN.
- Ack in DRAIN: data dropped, PS=00, back to FETCH. The next launch occurs at the following edge, not the ack edge.
- Redirect and ack in the same cycle: redirect wins. Ack data is dropped, PS is the redirect value, no PS=01, state goes to FETCH.
- Redirect while in DRAIN: PS applied, FIFO flushed again, stays DRAIN.
- Otherwise PS=00 and pc_k=0.
- FIFO:
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Pop is ignored in a redirect cycle.

## Timing
- Reset asserted (reset=0), immediately:
  - PS=00, pc_k=0, imem_req=0, imem_addr=0.
  - instr_valid=0, instr=0, instr_pc=0, fifo_count=0.
  - State FETCH; a pending read is abandoned.
  - While reset=0, imem_ack and redirect are ignored and PS=00.
- First imem_req rises at the first rising edge after reset returns to 1, with imem_addr=PC.
- Ack to instr_valid: 1 cycle (registered push).
- Back-to-back: one instruction per cycle with zero-wait ack and a draining FIFO.
- Redirect to the new-target request:
  - 1 edge if no read is pending: launch from the updated PC at the next edge.
  - Otherwise 1 edge after the drained ack.
- instr_valid deasserts at the redirect edge.
- PS and pc_k are combinational from state, imem_ack, redirect, redirect_abs and redirect_k, so the counter updates on the same edge.

## Configuration
- FETCH_STALL_COUNT_EN defined:
  - Adds output stall_count [15:0].
  - Increments each cycle imem_req=1 && imem_ack=0; saturates at 0xFFFF.
  - Cleared only by reset.
- FETCH_STALL_COUNT_EN undefined: no stall_count port, no counter logic.

## Test plan
- Zero-wait fill: PC model from 0, ack every cycle, rdata=0x8B000000+n, instr_ready=0.
  - Four pushes with instr_pc 0,4,8,C and fifo_count 4.
  - imem_req drops after the 4th ack.
  - One pop relaunches at addr 0x10.
- Wait states: ack 3 cycles after req.
  - imem_req/imem_addr stable 3 cycles, PS=00 during the wait.
  - PS=01 only on the ack cycle; instr_valid one cycle later.
- Relative redirect while idle with PC=0x10, redirect_k=0x40, redirect_abs=0.
  - PS=11, pc_k=0x40, FIFO flushed.
  - Next request imem_addr=0x54.
- Absolute redirect to 0x100 while a read of 0x20 is pending, ack 2 cycles later.
  - That ack's data is dropped, instr_valid stays 0.
  - Next request addr=0x100.
- Redirect coinciding with ack, redirect_abs=1.
  - PS=10 (not 01), data dropped, fifo_count=0.
- Reset pulled low mid-WAIT with 3 FIFO entries.
  - All outputs zero immediately.
  - After release, first request is at PC; stall_count=0 when FETCH_STALL_COUNT_EN is defined.
